imem_loader: RTL

- Writer side of the 64-word instruction memory: receives a program as a byte stream over a valid/ready interface.
- Assembles little-endian 32-bit words and drives the instruction memory write port, one word per write.
- Holds the pipelined core in reset (core_hold) until a complete, checksum-verified image has been written.
- Sits between the host/UART byte receiver and the instruction memory write port.

---
 rtl/imem_loader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Writer side of the instruction memory. Accepts a program image as a byte
//   stream over a valid/ready handshake and writes it one 32-bit word at a time.
//   The core is held in reset until a complete image with a matching checksum
//   has been written.
//
//   Stream: [count] [w0b0 w0b1 w0b2 w0b3] ... [w(N-1)b3] [checksum]
//     count 0 means DEPTH words, 1..DEPTH means that many, above DEPTH fails.
//     checksum is the XOR of all 4N data bytes.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         single-cycle pulse that begins a load (ignored while busy)
//   rx_valid      byte available on rx_data
//   rx_data       stream byte
//   rx_ready      loader accepts a byte this cycle
//   mem_we        one-cycle write strobe to the instruction memory
//   mem_addr      word address of the write
//   mem_wdata     word being written
//   core_hold     holds the core in reset; low only after a good load
//   busy          load in progress
//   done / err    outcome of the last load
//   words_loaded  words written in the current or last load
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [7:0]      DEPTH_B = 8'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_N   = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W:0]   n_words;
  logic [7:0]        csum;
  logic [23:0]       asm_p0;

  logic hs;
  logic can_start;
  logic last_byte;
  logic last_word;

  assign hs        = rx_valid & rx_ready;
  assign can_start = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
  assign last_byte = hs & (state == S_DATA) & (byte_idx == 2'd3);
  // words_loaded still holds the count before this word is counted.
  assign last_word = last_byte & ((words_loaded + ONE_N) == n_words);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    busy      = 1'b0;
    core_hold = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (can_start) state_nxt = S_COUNT;
      end
      S_COUNT: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (hs) begin
          if (rx_data > DEPTH_B) state_nxt = S_ERR;
          else                   state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (last_word) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (hs) begin
          if (rx_data == csum) state_nxt = S_DONE;
          else                 state_nxt = S_ERR;
        end
      end
      S_DONE: begin
        core_hold = 1'b0;
        done      = 1'b1;
        if (can_start) state_nxt = S_COUNT;
      end
      S_ERR: begin
        err = 1'b1;
        if (can_start) state_nxt = S_COUNT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Byte capture and word write stage: the 4th byte of a word is registered
  // straight into the write port, so the strobe lands one cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      byte_idx     <= '0;
      word_idx     <= '0;
      csum         <= '0;
      n_words      <= '0;
    end else begin
      mem_we <= 1'b0;
      if (can_start) begin
        words_loaded <= '0;
        byte_idx     <= '0;
        word_idx     <= '0;
        csum         <= '0;
      end
      if (hs && (state == S_COUNT)) begin
        n_words <= (rx_data == 8'd0) ? DEPTH_N : rx_data[ADDR_W:0];
      end
      if (hs && (state == S_DATA)) begin
        csum     <= csum ^ rx_data;
        byte_idx <= byte_idx + 2'd1;
        if (last_byte) begin
          mem_we       <= 1'b1;
          mem_addr     <= word_idx;
          mem_wdata    <= {rx_data, asm_p0};
          word_idx     <= word_idx + 1'b1;
          words_loaded <= words_loaded + ONE_N;
        end
      end
    end
  end

  // Lower three lanes of the word under assembly; pure data, never reset.
  always_ff @(posedge clk) begin
    if (hs && (state == S_DATA)) begin
      case (byte_idx)
        2'd0:    asm_p0[7:0]   <= rx_data;
        2'd1:    asm_p0[15:8]  <= rx_data;
        2'd2:    asm_p0[23:16] <= rx_data;
        default: asm_p0        <= asm_p0;
      endcase
    end
  end

endmodule
